axis_ofmaps_unload: RTL and testbench
=====================================

AXIS_OFMAPS_UNLOAD -- requirements
Module: axis_ofmaps_unload

Interface
REQ-001 SHALL have parameter C_M_AXIS_TDATA_WIDTH, default 32, AXI-Stream data width (only 32 supported).
REQ-002 SHALL have parameter MAC_NUM, default 256, number of MAC result lanes.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, number of wide result entries buffered.
REQ-004 SHALL have one clock and an asynchronous active-high reset, with ports as listed below.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 ofmaps_in  input  8*MAC_NUM  MAC results, lane k at bits [8k+7:8k].
REQ-008 ofmaps_valid  input  1  MAC write strobe for ofmaps_in.
REQ-009 output_channel  input  9  active lane count; latched on start.
REQ-010 frame_len  input  16  vectors per frame; latched on start.
REQ-011 start  input  1  one-cycle frame start request.
REQ-012 m_axis_tdata  output  32  stream data.
REQ-013 m_axis_tkeep  output  4  byte enables.
REQ-014 m_axis_tvalid, m_axis_tlast  output  1 each  AXIS master valid and last.
REQ-015 m_axis_tready  input  1  AXIS slave ready.
REQ-016 fifo_full, fifo_empty, busy, frame_done, overflow  output  1 each  status.

Function
REQ-017 FIFO SHALL hold FIFO_DEPTH entries of 8*MAC_NUM bits, plus registered write pointer, read pointer and count.
- fifo_full = (count == FIFO_DEPTH); fifo_empty = (count == 0); pointers wrap modulo FIFO_DEPTH.
REQ-018 Write SHALL occur when ofmaps_valid && !fifo_full, in any state, storing ofmaps_in at the write pointer.
REQ-019 ofmaps_valid while fifo_full SHALL drop the data and set sticky overflow.
- Same-cycle pop does not allow the write; no bypass.
- overflow clears only on reset or an accepted start.
REQ-020 FSM states SHALL be IDLE and STREAM.
- IDLE->STREAM on start; start latches output_channel and frame_len, and zeroes the beat and vector counters.
- start is ignored in STREAM.
REQ-021 Latched output_channel of 0 or >MAC_NUM SHALL be treated as MAC_NUM; latched frame_len of 0 SHALL be treated as 1.
REQ-022 beats_per_vector SHALL be ceil(channels/4).
- Beat b carries lanes 4b..4b+3, with lane 4b in tdata[7:0].
REQ-023 m_axis_tdata SHALL be the head entry slice for the current beat, with lanes >= channels forced to 0.
- m_axis_tkeep bit i = (4b+i < channels).
REQ-024 m_axis_tvalid SHALL be (state==STREAM && !fifo_empty).
- tdata, tkeep and tlast stay stable while tvalid && !tready.
REQ-025 A beat transfers when tvalid && tready.
- The beat counter increments on each transfer.
- On the last beat of a vector: beat counter -> 0, head entry popped (read pointer +1, count -1), vector counter +1.
REQ-026 A simultaneous write and pop SHALL leave count unchanged.
REQ-027 m_axis_tlast SHALL be high only on the last beat of the frame_len-th vector.
REQ-028 On the transfer of the tlast beat:
- frame_done pulses high for exactly one cycle (the next cycle).
- The FSM returns to IDLE; remaining FIFO entries are retained.
REQ-029 Latency: with FIFO empty in STREAM, an entry written at edge N SHALL assert tvalid during cycle N+1.
REQ-030 busy SHALL equal (state==STREAM).

Reset
REQ-031 rst SHALL act immediately, asynchronously, at any time including mid-beat or mid-frame.
REQ-032 On rst: state=IDLE; pointers, count and counters=0; FIFO contents discarded.
REQ-033 Output values under rst:
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0.
- frame_done=0, overflow=0, busy=0, fifo_empty=1, fifo_full=0.

Verification
REQ-034 Basic frame: output_channel=8, frame_len=1, one vector of lanes 0..7 = 0x01..0x08, tready=1.
- Beat 0: tdata=0x04030201, tkeep=0xF, tlast=0.
- Beat 1: tdata=0x08070605, tlast=1.
- Then frame_done pulse, FSM to IDLE.
REQ-035 Partial beat: output_channel=6.
- Beat 1 tkeep=0x3, tdata[31:16]=0.
REQ-036 Backpressure: tready low for 5 cycles mid-vector.
- tdata, tkeep, tlast stable.
- No beat lost or repeated.
REQ-037 Full/overflow: FIFO_DEPTH=2, three writes in IDLE.
- fifo_full=1 after the second write.
- Third write dropped, overflow=1.
- After start with frame_len=2, exactly 2 vectors streamed.
REQ-038 Simultaneous push/pop: write on the same cycle as the last-beat transfer.
- count unchanged.
- Next vector begins at beat 0 the following cycle.
REQ-039 Reset mid-frame: rst asserted during beat 3 of vector 1.
- tvalid=0 immediately, fifo_empty=1.
- After release, a new start streams correctly from vector 0.

Source files
------------

// File: rtl/axis_ofmaps_unload_if.sv
// ---------------------------------------------------------------------------
// axis_ofmaps_unload_if
// AXI-Stream bundle carrying unloaded MAC result beats.
//
// Signals:
//   tdata  [DATA_W-1:0]    stream data
//   tkeep  [DATA_W/8-1:0]  byte enables
//   tvalid                 master has a beat
//   tlast                  last beat of a frame
//   tready                 slave accepts the beat
//
// Modports:
//   master  drives tdata/tkeep/tvalid/tlast, samples tready
//   slave   samples tdata/tkeep/tvalid/tlast, drives tready
// ---------------------------------------------------------------------------
interface axis_ofmaps_unload_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_ofmaps_unload.sv
// ---------------------------------------------------------------------------
// axis_ofmaps_unload
// Buffers wide MAC result vectors in a small FIFO and unloads them as
// 32-bit AXI-Stream beats, four 8-bit lanes per beat, one frame per start.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   ofmaps_in        MAC results, lane k at [8k+7:8k]
//   ofmaps_valid     write strobe for ofmaps_in
//   output_channel   active lane count (latched on start)
//   frame_len        vectors per frame (latched on start)
//   start            one-cycle frame start request
//   m_axis           AXI-Stream master (tdata/tkeep/tvalid/tlast/tready)
//   fifo_full/empty  FIFO occupancy status
//   busy             frame in progress
//   frame_done       one-cycle pulse after the tlast beat transfers
//   overflow         sticky: a write arrived while the FIFO was full
//
// State | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; FIFO may still accept writes
// STREAM| emitting beats of the head entry until frame_len vectors
// ---------------------------------------------------------------------------
module axis_ofmaps_unload #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int MAC_NUM              = 256,
  parameter int FIFO_DEPTH           = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*MAC_NUM-1:0]  ofmaps_in,
  input  logic                  ofmaps_valid,
  input  logic [8:0]            output_channel,
  input  logic [15:0]           frame_len,
  input  logic                  start,
  axis_ofmaps_unload_if.master  m_axis,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int LANES     = C_M_AXIS_TDATA_WIDTH / 8;
  localparam int MAX_BEATS = (MAC_NUM + LANES - 1) / LANES;
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
  localparam int CH_W      = $clog2(MAC_NUM + 1);
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int PAD_W     = C_M_AXIS_TDATA_WIDTH * MAX_BEATS;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t              state_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic [BEAT_W-1:0]   beat_q;
  logic [BEAT_W-1:0]   beats_q;
  logic [15:0]         vec_q;
  logic [15:0]         frame_len_q;
  logic [CH_W-1:0]     channels_q;
  logic                frame_done_q;
  logic                overflow_q;

  logic [8*MAC_NUM-1:0] mem_q [FIFO_DEPTH];

  logic                fifo_full_w;
  logic                fifo_empty_w;
  logic                wr_en;
  logic                tvalid_w;
  logic                xfer;
  logic                last_beat;
  logic                last_vec;
  logic                pop;

  logic [CH_W-1:0]     chan_eff;
  logic [BEAT_W-1:0]   beats_eff;
  logic [15:0]         len_eff;

  logic [PAD_W-1:0]                head_pad;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] beat_word;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] data_w;
  logic [LANES-1:0]                keep_w;
  int                              beat_base;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full_w  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty_w = (count_q == '0);
  // Writes only land in free space; a same-cycle pop does not make room.
  assign wr_en        = ofmaps_valid && !fifo_full_w;

  assign tvalid_w  = (state_q == S_STREAM) && !fifo_empty_w;
  assign xfer      = tvalid_w && m_axis.tready;
  assign last_beat = (beat_q == beats_q - BEAT_W'(1));
  assign last_vec  = (vec_q == frame_len_q - 16'd1);
  assign pop       = xfer && last_beat;

  assign count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);

  // Out-of-range lane counts fall back to the full MAC width, and a zero
  // frame length still streams one vector.
  always_comb begin
    chan_eff = CH_W'(MAC_NUM);
    if (output_channel != 9'd0 && int'(output_channel) <= MAC_NUM)
      chan_eff = CH_W'(output_channel);
    beats_eff = BEAT_W'((int'(chan_eff) + LANES - 1) / LANES);
    len_eff   = (frame_len == 16'd0) ? 16'd1 : frame_len;
  end

  // Head entry padded to a whole number of beats so the last beat slice is
  // always in range even when MAC_NUM is not a multiple of the lane count.
  always_comb begin
    head_pad = '0;
    head_pad[8*MAC_NUM-1:0] = mem_q[rd_ptr_q];
  end

  always_comb begin
    beat_base = int'(beat_q) * C_M_AXIS_TDATA_WIDTH;
    beat_word = head_pad[beat_base +: C_M_AXIS_TDATA_WIDTH];
    keep_w    = '0;
    data_w    = '0;
    for (int i = 0; i < LANES; i++) begin
      keep_w[i] = (int'(beat_q) * LANES + i) < int'(channels_q);
      data_w[8*i +: 8] = keep_w[i] ? beat_word[8*i +: 8] : 8'h00;
    end
  end

  // Payload is gated by tvalid so the bus reads zero whenever idle or in reset.
  assign m_axis.tvalid = tvalid_w;
  assign m_axis.tdata  = tvalid_w ? data_w : '0;
  assign m_axis.tkeep  = tvalid_w ? keep_w : '0;
  assign m_axis.tlast  = tvalid_w && last_beat && last_vec;

  assign fifo_full  = fifo_full_w;
  assign fifo_empty = fifo_empty_w;
  assign busy       = (state_q == S_STREAM);
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= ofmaps_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      beat_q       <= '0;
      beats_q      <= '0;
      vec_q        <= '0;
      frame_len_q  <= '0;
      channels_q   <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      count_q      <= count_d;
      if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_STREAM;
            channels_q  <= chan_eff;
            beats_q     <= beats_eff;
            frame_len_q <= len_eff;
            beat_q      <= '0;
            vec_q       <= '0;
            overflow_q  <= 1'b0;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            if (last_beat) begin
              beat_q <= '0;
              vec_q  <= vec_q + 16'd1;
              if (last_vec) begin
                state_q      <= S_IDLE;
                frame_done_q <= 1'b1;
              end
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // A dropped write in the same cycle as a start still gets recorded.
      if (ofmaps_valid && fifo_full_w) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_ofmaps_unload.sv
module tb_axis_ofmaps_unload;
  localparam int MAC_NUM    = 16;
  localparam int FIFO_DEPTH = 2;

  logic                 clk;
  logic                 rst;
  logic [8*MAC_NUM-1:0] ofmaps_in;
  logic                 ofmaps_valid;
  logic [8:0]           output_channel;
  logic [15:0]          frame_len;
  logic                 start;
  logic                 fifo_full, fifo_empty, busy, frame_done, overflow;

  int n_checks;
  int n_fail;

  axis_ofmaps_unload_if #(.DATA_W(32)) m_axis_if ();

  axis_ofmaps_unload #(
    .C_M_AXIS_TDATA_WIDTH(32),
    .MAC_NUM(MAC_NUM),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ofmaps_in(ofmaps_in),
    .ofmaps_valid(ofmaps_valid),
    .output_channel(output_channel),
    .frame_len(frame_len),
    .start(start),
    .m_axis(m_axis_if),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .busy(busy),
    .frame_done(frame_done),
    .overflow(overflow)
  );

  // {tvalid, tlast, tkeep, tdata} and {busy, frame_done, overflow, full, empty}
  wire [37:0] beat_obs = {m_axis_if.tvalid, m_axis_if.tlast, m_axis_if.tkeep, m_axis_if.tdata};
  wire [4:0]  stat_obs = {busy, frame_done, overflow, fifo_full, fifo_empty};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_vec(input logic [7:0] base);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = base + 8'(k);
    return v;
  endfunction

  task automatic push(input logic [127:0] v);
    ofmaps_in    = v;
    ofmaps_valid = 1'b1;
    tick();
    ofmaps_valid = 1'b0;
  endtask

  task automatic do_start(input logic [8:0] oc, input logic [15:0] fl);
    output_channel = oc;
    frame_len      = fl;
    start          = 1'b1;
    tick();
    start          = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] eb;
    logic [4:0]  es;
    eb = 38'h0;
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL reset_bus: got %h expected %h", beat_obs, eb);
    end
    es = 5'b00001;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL reset_status: got %b expected %b", stat_obs, es);
    end
  endtask

  task automatic test_basic();
    logic [37:0] eb;
    logic [4:0]  es;
    m_axis_if.tready = 1'b1;
    do_start(9'd8, 16'd1);
    es = 5'b10001;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL basic_started: got %b expected %b", stat_obs, es);
    end
    eb = 38'h0;
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL basic_no_valid_when_empty: got %h expected %h", beat_obs, eb);
    end
    push(mk_vec(8'h01));
    eb = {1'b1, 1'b0, 4'hF, 32'h04030201};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL basic_beat0: got %h expected %h", beat_obs, eb);
    end
    tick();
    eb = {1'b1, 1'b1, 4'hF, 32'h08070605};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL basic_beat1: got %h expected %h", beat_obs, eb);
    end
    tick();
    es = 5'b01001;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL basic_done: got %b expected %b", stat_obs, es);
    end
    tick();
    es = 5'b00001;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL basic_done_one_cycle: got %b expected %b", stat_obs, es);
    end
  endtask

  task automatic test_partial();
    logic [37:0] eb;
    logic [4:0]  es;
    m_axis_if.tready = 1'b1;
    do_start(9'd6, 16'd1);
    push(mk_vec(8'h11));
    eb = {1'b1, 1'b0, 4'hF, 32'h14131211};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL partial_beat0: got %h expected %h", beat_obs, eb);
    end
    tick();
    eb = {1'b1, 1'b1, 4'h3, 32'h00001615};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL partial_beat1: got %h expected %h", beat_obs, eb);
    end
    tick();
    es = 5'b01001;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL partial_done: got %b expected %b", stat_obs, es);
    end
  endtask

  // Lane count above MAC_NUM and zero frame length: full 16 lanes, one vector.
  task automatic test_defaults();
    logic [37:0] exp_beats [4];
    logic [4:0]  es;
    exp_beats[0] = {1'b1, 1'b0, 4'hF, 32'h43424140};
    exp_beats[1] = {1'b1, 1'b0, 4'hF, 32'h47464544};
    exp_beats[2] = {1'b1, 1'b0, 4'hF, 32'h4B4A4948};
    exp_beats[3] = {1'b1, 1'b1, 4'hF, 32'h4F4E4D4C};
    m_axis_if.tready = 1'b1;
    do_start(9'd300, 16'd0);
    push(mk_vec(8'h40));
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (beat_obs !== exp_beats[b]) begin
        n_fail++;
        $display("FAIL defaults_beat%0d: got %h expected %h", b, beat_obs, exp_beats[b]);
      end
      tick();
    end
    es = 5'b01001;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL defaults_done: got %b expected %b", stat_obs, es);
    end
  endtask

  task automatic test_backpressure();
    logic [37:0] eb;
    logic [4:0]  es;
    m_axis_if.tready = 1'b0;
    do_start(9'd16, 16'd1);
    push(mk_vec(8'h20));
    eb = {1'b1, 1'b0, 4'hF, 32'h23222120};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL bp_beat0: got %h expected %h", beat_obs, eb);
    end
    m_axis_if.tready = 1'b1;
    tick();
    m_axis_if.tready = 1'b0;
    eb = {1'b1, 1'b0, 4'hF, 32'h27262524};
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (beat_obs !== eb) begin
        n_fail++;
        $display("FAIL bp_hold_cycle%0d: got %h expected %h", c, beat_obs, eb);
      end
      tick();
    end
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL bp_hold_end: got %h expected %h", beat_obs, eb);
    end
    m_axis_if.tready = 1'b1;
    tick();
    eb = {1'b1, 1'b0, 4'hF, 32'h2B2A2928};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL bp_beat2: got %h expected %h", beat_obs, eb);
    end
    tick();
    eb = {1'b1, 1'b1, 4'hF, 32'h2F2E2D2C};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL bp_beat3: got %h expected %h", beat_obs, eb);
    end
    tick();
    es = 5'b01001;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL bp_done: got %b expected %b", stat_obs, es);
    end
  endtask

  task automatic test_overflow();
    logic [37:0] eb;
    logic [4:0]  es;
    m_axis_if.tready = 1'b1;
    push(mk_vec(8'h50));
    es = 5'b00000;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL ovf_one_entry: got %b expected %b", stat_obs, es);
    end
    push(mk_vec(8'h60));
    es = 5'b00010;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL ovf_full: got %b expected %b", stat_obs, es);
    end
    push(mk_vec(8'h70));
    es = 5'b00110;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b expected %b", stat_obs, es);
    end
    do_start(9'd4, 16'd2);
    es = 5'b10010;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL ovf_cleared_by_start: got %b expected %b", stat_obs, es);
    end
    eb = {1'b1, 1'b0, 4'hF, 32'h53525150};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL ovf_vec0: got %h expected %h", beat_obs, eb);
    end
    tick();
    eb = {1'b1, 1'b1, 4'hF, 32'h63626160};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL ovf_vec1: got %h expected %h", beat_obs, eb);
    end
    tick();
    es = 5'b01001;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL ovf_done_empty: got %b expected %b", stat_obs, es);
    end
    eb = 38'h0;
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL ovf_third_dropped: got %h expected %h", beat_obs, eb);
    end
  endtask

  task automatic test_push_pop();
    logic [37:0] eb;
    logic [4:0]  es;
    m_axis_if.tready = 1'b1;
    do_start(9'd8, 16'd3);
    push(mk_vec(8'h80));
    eb = {1'b1, 1'b0, 4'hF, 32'h83828180};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL pp_v0_beat0: got %h expected %h", beat_obs, eb);
    end
    tick();
    eb = {1'b1, 1'b0, 4'hF, 32'h87868584};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL pp_v0_beat1: got %h expected %h", beat_obs, eb);
    end
    push(mk_vec(8'h90));
    es = 5'b10000;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL pp_count_unchanged: got %b expected %b", stat_obs, es);
    end
    eb = {1'b1, 1'b0, 4'hF, 32'h93929190};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL pp_v1_beat0: got %h expected %h", beat_obs, eb);
    end
    tick();
    eb = {1'b1, 1'b0, 4'hF, 32'h97969594};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL pp_v1_beat1: got %h expected %h", beat_obs, eb);
    end
    tick();
    es = 5'b10001;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL pp_wait_v2: got %b expected %b", stat_obs, es);
    end
    push(mk_vec(8'hA0));
    eb = {1'b1, 1'b0, 4'hF, 32'hA3A2A1A0};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL pp_v2_beat0: got %h expected %h", beat_obs, eb);
    end
    tick();
    eb = {1'b1, 1'b1, 4'hF, 32'hA7A6A5A4};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL pp_v2_beat1: got %h expected %h", beat_obs, eb);
    end
    tick();
    es = 5'b01001;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL pp_done: got %b expected %b", stat_obs, es);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [37:0] eb;
    logic [4:0]  es;
    m_axis_if.tready = 1'b0;
    do_start(9'd16, 16'd2);
    push(mk_vec(8'hB0));
    push(mk_vec(8'hC0));
    m_axis_if.tready = 1'b1;
    repeat (7) tick();
    eb = {1'b1, 1'b1, 4'hF, 32'hCFCECDCC};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL rmid_v1_beat3: got %h expected %h", beat_obs, eb);
    end
    rst = 1'b1;
    #1;
    eb = 38'h0;
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL rmid_bus_in_reset: got %h expected %h", beat_obs, eb);
    end
    es = 5'b00001;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL rmid_status_in_reset: got %b expected %b", stat_obs, es);
    end
    rst = 1'b0;
    tick();
    do_start(9'd4, 16'd1);
    es = 5'b10001;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL rmid_restart: got %b expected %b", stat_obs, es);
    end
    push(mk_vec(8'hD0));
    eb = {1'b1, 1'b1, 4'hF, 32'hD3D2D1D0};
    n_checks++;
    if (beat_obs !== eb) begin
      n_fail++;
      $display("FAIL rmid_new_vec0: got %h expected %h", beat_obs, eb);
    end
    tick();
    es = 5'b01001;
    n_checks++;
    if (stat_obs !== es) begin
      n_fail++;
      $display("FAIL rmid_done: got %b expected %b", stat_obs, es);
    end
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    rst              = 1'b1;
    ofmaps_in        = '0;
    ofmaps_valid     = 1'b0;
    output_channel   = 9'd0;
    frame_len        = 16'd0;
    start            = 1'b0;
    m_axis_if.tready = 1'b0;
    #2;
    test_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_basic();
    test_partial();
    test_defaults();
    test_backpressure();
    test_overflow();
    test_push_pop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
